// File: rtl/running_extremum_tracker_if.sv
// Bundle of the sample stream, the external comparator link and the
// tracker results. The tracker drives through the slave modport and the
// producer/comparator side uses master. When TRACKER_RANGE_EN is defined,
// the bundle also carries range_val.
interface running_extremum_tracker_if #(
   parameter int N  = 8,
   parameter int CW = 8
);
   logic          in_valid;
   logic [N-1:0]  in_data;
   logic          in_ready;
   logic [N-1:0]  cmp_a;
   logic [N-1:0]  cmp_b;
   logic          cmp_eq;
   logic          cmp_lt;
   logic [N-1:0]  min_val;
   logic [N-1:0]  max_val;
   logic [CW-1:0] count;
   logic [CW-1:0] tie_count;
   logic          valid;
   logic          done;
`ifdef TRACKER_RANGE_EN
   logic [N-1:0]  range_val;

   modport master (
      output in_valid, in_data, cmp_eq, cmp_lt,
      input  in_ready, cmp_a, cmp_b, min_val, max_val, count, tie_count,
             valid, done, range_val
   );
   modport slave (
      input  in_valid, in_data, cmp_eq, cmp_lt,
      output in_ready, cmp_a, cmp_b, min_val, max_val, count, tie_count,
             valid, done, range_val
   );
`else
   modport master (
      output in_valid, in_data, cmp_eq, cmp_lt,
      input  in_ready, cmp_a, cmp_b, min_val, max_val, count, tie_count,
             valid, done
   );
   modport slave (
      input  in_valid, in_data, cmp_eq, cmp_lt,
      output in_ready, cmp_a, cmp_b, min_val, max_val, count, tie_count,
             valid, done
   );
`endif
endinterface

// File: rtl/running_extremum_tracker.sv
// Running min/max tracker that uses an external comparator for every
// ordering decision. Each sample after the first takes two compare cycles:
// first against the stored minimum, then against the stored maximum.
// Defining TRACKER_RANGE_EN adds the registered output range_val, which
// holds max_val - min_val.
module running_extremum_tracker #(
   parameter int N  = 8,
   parameter int CW = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   running_extremum_tracker_if.slave bus
);

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_READY   = 2'd1,
      ST_CMP_MIN = 2'd2,
      ST_CMP_MAX = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  smp_q, smp_d;
   logic [N-1:0]  min_q, min_d;
   logic [N-1:0]  max_q, max_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] tie_q, tie_d;
   logic          valid_q, valid_d;
   logic          done_q, done_d;
`ifdef TRACKER_RANGE_EN
   logic [N-1:0]  range_q, range_d;
`endif

   logic          in_ready_s;
   logic          accept_s;
   logic [N-1:0]  cmp_a_s;
   logic [N-1:0]  cmp_b_s;

   // Saturating counter increment: holds at all-ones instead of wrapping.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      if (v == {CW{1'b1}}) begin
         return v;
      end else begin
         return v + CW'(1'b1);
      end
   endfunction

   // Handshake and comparator operand selection, decoded from state only.
   always_comb begin
      in_ready_s = 1'b0;
      cmp_a_s    = {N{1'b0}};
      cmp_b_s    = {N{1'b0}};
      case (state_q)
         ST_EMPTY:   in_ready_s = 1'b1;
         ST_READY:   in_ready_s = 1'b1;
         ST_CMP_MIN: begin
            cmp_a_s = smp_q;
            cmp_b_s = min_q;
         end
         ST_CMP_MAX: begin
            cmp_a_s = max_q;
            cmp_b_s = smp_q;
         end
         default: begin
            in_ready_s = 1'b0;
         end
      endcase
      accept_s = bus.in_valid & in_ready_s;
   end

   // Next-state logic. Clear wins over everything and drops any in-flight update.
   always_comb begin
      state_d = state_q;
      smp_d   = smp_q;
      min_d   = min_q;
      max_d   = max_q;
      count_d = count_q;
      tie_d   = tie_q;
      valid_d = valid_q;
      done_d  = 1'b0;
`ifdef TRACKER_RANGE_EN
      range_d = range_q;
`endif
      if (clear) begin
         state_d = ST_EMPTY;
         smp_d   = {N{1'b0}};
         min_d   = {N{1'b0}};
         max_d   = {N{1'b0}};
         count_d = {CW{1'b0}};
         tie_d   = {CW{1'b0}};
         valid_d = 1'b0;
`ifdef TRACKER_RANGE_EN
         range_d = {N{1'b0}};
`endif
      end else begin
         case (state_q)
            ST_EMPTY: begin
               // The first sample seeds both extremes and needs no compare.
               if (accept_s) begin
                  min_d   = bus.in_data;
                  max_d   = bus.in_data;
                  count_d = CW'(1'b1);
                  valid_d = 1'b1;
                  done_d  = 1'b1;
                  state_d = ST_READY;
`ifdef TRACKER_RANGE_EN
                  range_d = {N{1'b0}};
`endif
               end else begin
                  state_d = ST_EMPTY;
               end
            end
            ST_READY: begin
               if (accept_s) begin
                  smp_d   = bus.in_data;
                  state_d = ST_CMP_MIN;
               end else begin
                  state_d = ST_READY;
               end
            end
            ST_CMP_MIN: begin
               if (bus.cmp_lt) begin
                  min_d = smp_q;
               end else begin
                  min_d = min_q;
               end
               state_d = ST_CMP_MAX;
            end
            ST_CMP_MAX: begin
               if (bus.cmp_lt) begin
                  max_d = smp_q;
               end else begin
                  max_d = max_q;
               end
               if (bus.cmp_eq) begin
                  tie_d = sat_inc(tie_q);
               end else begin
                  tie_d = tie_q;
               end
               count_d = sat_inc(count_q);
               done_d  = 1'b1;
               state_d = ST_READY;
`ifdef TRACKER_RANGE_EN
               // min_q is already final here; it was settled in CMP_MIN.
               range_d = max_d - min_q;
`endif
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   // State and result registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         smp_q   <= {N{1'b0}};
         min_q   <= {N{1'b0}};
         max_q   <= {N{1'b0}};
         count_q <= {CW{1'b0}};
         tie_q   <= {CW{1'b0}};
         valid_q <= 1'b0;
         done_q  <= 1'b0;
`ifdef TRACKER_RANGE_EN
         range_q <= {N{1'b0}};
`endif
      end else begin
         state_q <= state_d;
         smp_q   <= smp_d;
         min_q   <= min_d;
         max_q   <= max_d;
         count_q <= count_d;
         tie_q   <= tie_d;
         valid_q <= valid_d;
         done_q  <= done_d;
`ifdef TRACKER_RANGE_EN
         range_q <= range_d;
`endif
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.cmp_a     = cmp_a_s;
   assign bus.cmp_b     = cmp_b_s;
   assign bus.min_val   = min_q;
   assign bus.max_val   = max_q;
   assign bus.count     = count_q;
   assign bus.tie_count = tie_q;
   assign bus.valid     = valid_q;
   assign bus.done      = done_q;
`ifdef TRACKER_RANGE_EN
   assign bus.range_val = range_q;
`endif

endmodule

// File: tb/tb_running_extremum_tracker.sv
// Directed bench for running_extremum_tracker. It models the external
// comparator and keeps a reference model whose expected results are queued
// at sample acceptance. Each queued result is checked when done pulses.
module tb_running_extremum_tracker;

   localparam int N  = 8;
   localparam int CW = 8;

   typedef struct packed {
      logic [7:0] mn;
      logic [7:0] mx;
      logic [7:0] cnt;
      logic [7:0] tie;
      logic [7:0] rng;
   } exp_t;

   logic clk;
   logic rst_n;
   logic clear;

   running_extremum_tracker_if #(.N(N), .CW(CW)) bus ();

   running_extremum_tracker #(.N(N), .CW(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .bus   (bus)
   );

   // External comparator: unsigned EQ/LT on A/B.
   assign bus.cmp_eq = (bus.cmp_a == bus.cmp_b);
   assign bus.cmp_lt = (bus.cmp_a <  bus.cmp_b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_assert = 0;
   int   n_fail   = 0;
   exp_t sb[$];

   logic [7:0] m_min, m_max, m_cnt, m_tie;
   logic       m_valid;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] sat8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   task automatic model_reset();
      m_min = 8'd0; m_max = 8'd0; m_cnt = 8'd0; m_tie = 8'd0; m_valid = 1'b0;
      sb.delete();
   endtask

   task automatic model_accept(input logic [7:0] d);
      exp_t e;
      if (!m_valid) begin
         m_min = d; m_max = d; m_cnt = 8'd1; m_tie = 8'd0; m_valid = 1'b1;
      end else begin
         if (d == m_max) m_tie = sat8(m_tie);
         if (d < m_min)  m_min = d;
         if (d > m_max)  m_max = d;
         m_cnt = sat8(m_cnt);
      end
      e.mn = m_min; e.mx = m_max; e.cnt = m_cnt; e.tie = m_tie; e.rng = m_max - m_min;
      sb.push_back(e);
   endtask

   // Scoreboard: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("done_unexpected", 32'(bus.done), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_min",   32'(bus.min_val),   32'(e.mn));
            chk("sb_max",   32'(bus.max_val),   32'(e.mx));
            chk("sb_count", 32'(bus.count),     32'(e.cnt));
            chk("sb_tie",   32'(bus.tie_count), 32'(e.tie));
            chk("sb_valid", 32'(bus.valid),     32'd1);
`ifdef TRACKER_RANGE_EN
            chk("sb_range", 32'(bus.range_val), 32'(e.rng));
`endif
         end
      end
   end

   // Call at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [7:0] d, output int waits);
      waits = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      while (bus.in_ready !== 1'b1 && waits < 10) begin
         @(negedge clk);
         waits++;
      end
      if (bus.in_ready !== 1'b1) begin
         chk("accept_timeout", 32'(bus.in_ready), 32'd1);
      end else begin
         @(posedge clk);
         model_accept(d);
         @(negedge clk);
      end
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.in_data  = 8'd0;
   endtask

   task automatic drain();
      int cyc;
      cyc = 0;
      while (sb.size() != 0 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("drain", 32'(sb.size()), 32'd0);
   endtask

   task automatic do_clear();
      bus.in_valid = 1'b0;
      clear = 1'b1;
      @(posedge clk);
      model_reset();
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic chk_state(input string tag);
      chk({tag, "_min"},   32'(bus.min_val),   32'(m_min));
      chk({tag, "_max"},   32'(bus.max_val),   32'(m_max));
      chk({tag, "_count"}, 32'(bus.count),     32'(m_cnt));
      chk({tag, "_tie"},   32'(bus.tie_count), 32'(m_tie));
      chk({tag, "_valid"}, 32'(bus.valid),     32'(m_valid));
`ifdef TRACKER_RANGE_EN
      chk({tag, "_range"}, 32'(bus.range_val), 32'(m_max - m_min));
`endif
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_min"},   32'(bus.min_val),   32'd0);
      chk({tag, "_max"},   32'(bus.max_val),   32'd0);
      chk({tag, "_count"}, 32'(bus.count),     32'd0);
      chk({tag, "_tie"},   32'(bus.tie_count), 32'd0);
      chk({tag, "_valid"}, 32'(bus.valid),     32'd0);
      chk({tag, "_done"},  32'(bus.done),      32'd0);
      chk({tag, "_cmpa"},  32'(bus.cmp_a),     32'd0);
      chk({tag, "_cmpb"},  32'(bus.cmp_b),     32'd0);
`ifdef TRACKER_RANGE_EN
      chk({tag, "_range"}, 32'(bus.range_val), 32'd0);
`endif
   endtask

   initial begin
      int w;
      rst_n = 1'b0;
      clear = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'd0;
      model_reset();

      // Reset state.
      repeat (3) @(negedge clk);
      chk_zero("reset");
      chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // Single sample through the EMPTY path: done one cycle after accept.
      send(8'h5A, w);
      chk("first_done", 32'(bus.done), 32'd1);
      chk("first_min",  32'(bus.min_val), 32'h5A);
      chk("first_max",  32'(bus.max_val), 32'h5A);
      idle();
      drain();
      chk_state("single");

      // Clear returns to empty.
      do_clear();
      chk_zero("clear1");

      // Back-to-back stream with in_valid held high.
      send(8'h40, w);
      send(8'h10, w);
      chk("b2b_wait_10", 32'(w), 32'd0);
      chk("b2b_cmpmin_a", 32'(bus.cmp_a), 32'h10);
      chk("b2b_cmpmin_b", 32'(bus.cmp_b), 32'h40);
      chk("b2b_ready_lo", 32'(bus.in_ready), 32'd0);
      send(8'hF0, w);
      chk("b2b_wait_F0", 32'(w), 32'd2);
      send(8'h80, w);
      chk("b2b_wait_80", 32'(w), 32'd2);
      idle();
      drain();
      chk_state("stream");
      chk("stream_min", 32'(bus.min_val), 32'h10);
      chk("stream_max", 32'(bus.max_val), 32'hF0);
      chk("stream_cnt", 32'(bus.count), 32'd4);

      // Equal samples at the max count as ties.
      do_clear();
      send(8'hFF, w);
      send(8'hFF, w);
      send(8'hFF, w);
      idle();
      drain();
      chk_state("ties");
      chk("ties_tie", 32'(bus.tie_count), 32'd2);

      // Boundary values.
      do_clear();
      send(8'h00, w);
      send(8'hFF, w);
      idle();
      drain();
      chk_state("bound");
      chk("bound_max", 32'(bus.max_val), 32'hFF);

      // Clear during CMP_MAX of 8'h01 following 8'h80 aborts the update.
      do_clear();
      send(8'h80, w);
      send(8'h01, w);
      idle();
      chk("abort_cmpmin_a", 32'(bus.cmp_a), 32'h01);
      @(negedge clk);
      chk("abort_cmpmax_a", 32'(bus.cmp_a), 32'h80);
      chk("abort_cmpmax_b", 32'(bus.cmp_b), 32'h01);
      clear = 1'b1;
      @(posedge clk);
      model_reset();
      @(negedge clk);
      clear = 1'b0;
      chk_zero("abort");
      @(negedge clk);
      chk("abort_no_done", 32'(bus.done), 32'd0);
      send(8'h33, w);
      chk("after_abort_done", 32'(bus.done), 32'd1);
      idle();
      drain();
      chk_state("after_abort");

      // Counter saturation.
      do_clear();
      for (int i = 0; i < 260; i++) send(8'hFF, w);
      idle();
      drain();
      chk_state("sat");
      chk("sat_count", 32'(bus.count), 32'hFF);
      chk("sat_tie",   32'(bus.tie_count), 32'hFF);

      // Asynchronous reset in the middle of CMP_MIN.
      do_clear();
      send(8'h12, w);
      send(8'h34, w);
      idle();
      chk("arst_cmpmin_a", 32'(bus.cmp_a), 32'h34);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("arst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_zero("arst_after");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
